alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_arbiter_rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, arbiter FSM states and requester IDs.
package alu_pkg;

    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned ALU_NUM_OPS = 10;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_BRU = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic any_valid;

    always_comb begin
        any_valid = |valid_i;
        gnt_id_o  = 1'b0;
        if (valid_i == 2'b11) begin
            gnt_id_o = rr_ptr_i;
        end else if (valid_i == 2'b10) begin
            gnt_id_o = 1'b1;
        end
        gnt_o = {any_valid & gnt_id_o, any_valid & ~gnt_id_o};
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage and the address/branch unit.
// Optional per-requester completion counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OP_WIDTH      = ALU_OP_W,
    parameter int unsigned NUM_LEGAL_OPS = ALU_NUM_OPS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_result,
    output logic                  resp0_zero,
    output logic                  resp0_err,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_result,
    output logic                  resp1_zero,
    output logic                  resp1_err,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic [31:0]           perf_cnt0,
    output logic [31:0]           perf_cnt1
);

    localparam logic [OP_WIDTH:0] LEGAL_LIM = (OP_WIDTH+1)'(NUM_LEGAL_OPS);

    arb_state_e            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  gnt_id_q, gnt_id_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  err_q, err_d;

    logic [1:0]            gnt;
    logic                  win_id;
    logic                  resp_hs;
    logic [OP_WIDTH-1:0]   win_op;

    rr_arb2 u_rr_arb2 (
        .valid_i  ({req1_valid, req0_valid}),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (win_id)
    );

    // Next-state, operand capture and handshake decode
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_hs    = 1'b0;
        win_op     = win_id ? req1_op : req0_op;

        case (state_q)
            ST_IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                if (|gnt) begin
                    state_d    = ST_EXEC;
                    gnt_id_d   = win_id;
                    alu_a_d    = win_id ? req1_a : req0_a;
                    alu_b_d    = win_id ? req1_b : req0_b;
                    alu_ctrl_d = win_op;
                    err_d      = ({1'b0, win_op} >= LEGAL_LIM);
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp_hs = (gnt_id_q == REQ_BRU) ? resp1_ready : resp0_ready;
                if (resp_hs) begin
                    rr_ptr_d = ~gnt_id_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            gnt_id_q   <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_ctrl_q;
    assign resp0_valid  = (state_q == ST_RESP) && (gnt_id_q == REQ_EXE);
    assign resp1_valid  = (state_q == ST_RESP) && (gnt_id_q == REQ_BRU);
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;
    assign resp0_err    = err_q;
    assign resp1_err    = err_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_cnt0_q, perf_cnt0_d;
    logic [31:0] perf_cnt1_q, perf_cnt1_d;

    // Saturating completion counters, bumped on the response handshake
    always_comb begin
        perf_cnt0_d = perf_cnt0_q;
        perf_cnt1_d = perf_cnt1_q;
        if (resp_hs && (gnt_id_q == REQ_EXE) && (perf_cnt0_q != 32'hFFFF_FFFF)) begin
            perf_cnt0_d = perf_cnt0_q + 32'd1;
        end
        if (resp_hs && (gnt_id_q == REQ_BRU) && (perf_cnt1_q != 32'hFFFF_FFFF)) begin
            perf_cnt1_d = perf_cnt1_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt0_q <= '0;
            perf_cnt1_q <= '0;
        end else begin
            perf_cnt0_q <= perf_cnt0_d;
            perf_cnt1_q <= perf_cnt1_d;
        end
    end

    assign perf_cnt0 = perf_cnt0_q;
    assign perf_cnt1 = perf_cnt1_q;
`else
    assign perf_cnt0 = '0;
    assign perf_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU closes the loop on alu_a/alu_b/alu_control.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_zero, resp1_zero, resp0_err, resp1_err;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;
    logic [31:0] perf_cnt0, perf_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_err(resp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU, anything else gives 0
    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[4:0];
            4'd6:    alu_result = alu_a >> alu_b[4:0];
            4'd7:    alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'd8:    alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            4'd9:    alu_result = {31'd0, (alu_a < alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Stimulus only: one uncontended op on requester id with response ready held high
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; resp0_ready = 1'b1;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; resp1_ready = 1'b1;
        end
        #1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); end
        n_cmp++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_resp_valid: got %b%b want 00", resp1_valid, resp0_valid); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'd0) begin n_bad++;
            $display("FAIL reset_alu_regs: got %h %h %h want 0 0 0", alu_a, alu_b, alu_control); end
        n_cmp++; if (resp0_result !== 32'd0 || resp0_zero !== 1'b0 || resp0_err !== 1'b0) begin n_bad++;
            $display("FAIL reset_result: got %h z%b e%b want 0 z0 e0", resp0_result, resp0_zero, resp0_err); end
        n_cmp++; if (perf_cnt0 !== 32'd0 || perf_cnt1 !== 32'd0) begin n_bad++;
            $display("FAIL reset_perf: got %0d %0d want 0 0", perf_cnt0, perf_cnt1); end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0; resp0_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++;
            $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready); end
        step();
        req0_valid = 1'b0;
        n_cmp++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_control !== 4'd0) begin n_bad++;
            $display("FAIL single_alu_ops: got %0d %0d %0d want 5 7 0", alu_a, alu_b, alu_control); end
        n_cmp++; if (resp0_valid !== 1'b0 || req0_ready !== 1'b0) begin n_bad++;
            $display("FAIL single_exec: got valid %b ready %b want 0 0", resp0_valid, req0_ready); end
        step();
        n_cmp++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin n_bad++;
            $display("FAIL single_resp_valid: got %b%b want 01", resp1_valid, resp0_valid); end
        n_cmp++; if (resp0_result !== 32'd12 || resp0_zero !== 1'b0 || resp0_err !== 1'b0) begin n_bad++;
            $display("FAIL single_result: got %0d z%b e%b want 12 z0 e0", resp0_result, resp0_zero, resp0_err); end
        step();
        resp0_ready = 1'b0;
        n_cmp++; if (resp0_valid !== 1'b0 || alu_a !== 32'd5 || alu_control !== 4'd0) begin n_bad++;
            $display("FAIL single_done: got valid %b a %0d ctl %0d want 0 5 0", resp0_valid, alu_a, alu_control); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_res;
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'd1;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'd3;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++;
            $display("FAIL cont_first_grant: got %b%b want 01", req1_ready, req0_ready); end
        step();
        req0_valid = 1'b0;
        n_cmp++; if (req1_ready !== 1'b0) begin n_bad++;
            $display("FAIL cont_busy_ready: got %b want 0", req1_ready); end
        step();
        n_cmp++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_result !== 32'd0 || resp0_zero !== 1'b1) begin n_bad++;
            $display("FAIL cont_sub: got v%b%b %h z%b want v01 0 z1", resp1_valid, resp0_valid, resp0_result, resp0_zero); end
        step();
        n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_bad++;
            $display("FAIL cont_second_grant: got %b%b want 10", req1_ready, req0_ready); end
        step();
        req1_valid = 1'b0;
        step();
        n_cmp++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_result !== 32'hFF || resp1_zero !== 1'b0) begin n_bad++;
            $display("FAIL cont_or: got v%b%b %h z%b want v10 ff z0", resp1_valid, resp0_valid, resp1_result, resp1_zero); end
        step();
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'(k); req0_op = 4'd0;
            req1_valid = 1'b1; req1_a = 32'd200; req1_b = 32'(k); req1_op = 4'd0;
            exp_res = ((k % 2) == 0) ? 32'(100 + k) : 32'(200 + k);
            #1;
            n_cmp++; if (req0_ready !== ((k % 2) == 0) || req1_ready !== ((k % 2) == 1)) begin n_bad++;
                $display("FAIL cont_rr_round%0d: got %b%b want winner %0d", k, req1_ready, req0_ready, k % 2); end
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            step();
            n_cmp++; if (((k % 2) == 0 ? resp0_valid : resp1_valid) !== 1'b1 || resp0_result !== exp_res) begin n_bad++;
                $display("FAIL cont_rr_resp%0d: got v%b%b %0d want %0d", k, resp1_valid, resp0_valid, resp0_result, exp_res); end
            step();
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 4'd7;
        resp1_ready = 1'b0;
        #1;
        step();
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (resp1_valid !== 1'b1 || resp1_result !== 32'hF800_0000) begin n_bad++;
                $display("FAIL bp_hold%0d: got v%b %h want v1 f8000000", c, resp1_valid, resp1_result); end
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_bad++;
                $display("FAIL bp_ready%0d: got %b%b want 00", c, req1_ready, req0_ready); end
            step();
        end
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;
        n_cmp++; if (resp1_valid !== 1'b0 || req0_ready !== 1'b1) begin n_bad++;
            $display("FAIL bp_release: got v%b r0 %b want v0 r1", resp1_valid, req0_ready); end
        req0_valid = 1'b0;
        #1;
    endtask

    task automatic test_illegal();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b1100; resp0_ready = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        n_cmp++; if (alu_control !== 4'b1100) begin n_bad++;
            $display("FAIL ill_ctl: got %b want 1100", alu_control); end
        step();
        n_cmp++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd0 || resp0_zero !== 1'b1 || resp0_err !== 1'b1) begin n_bad++;
            $display("FAIL ill_resp: got v%b %h z%b e%b want v1 0 z1 e1", resp0_valid, resp0_result, resp0_zero, resp0_err); end
        step();
        resp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0; resp0_ready = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'd0) begin n_bad++;
            $display("FAIL rst_mid_alu: got %h %h %h want 0 0 0", alu_a, alu_b, alu_control); end
        n_cmp++; if (resp0_zero !== 1'b0 || resp0_err !== 1'b0 || resp0_valid !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_resp: got z%b e%b v%b want z0 e0 v0", resp0_zero, resp0_err, resp0_valid); end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_stale: got %b%b want 00", resp1_valid, resp0_valid); end
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'd0;
        req1_valid = 1'b1; req1_a = 32'd7;  req1_b = 32'd7;  req1_op = 4'd0;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_pref: got %b%b want 01", req1_ready, req0_ready); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        n_cmp++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd30) begin n_bad++;
            $display("FAIL rst_mid_after: got v%b %0d want v1 30", resp0_valid, resp0_result); end
        step();
        resp0_ready = 1'b0;
    endtask

    task automatic test_perf();
        apply_reset();
        do_op(0, 32'd1, 32'd1, 4'd0);
        do_op(1, 32'd2, 32'd2, 4'd0);
        do_op(0, 32'd3, 32'd3, 4'd2);
        do_op(1, 32'd4, 32'd4, 4'd4);
        do_op(0, 32'd5, 32'd5, 4'b1111);
`ifdef ALU_ARB_PERF_EN
        n_cmp++; if (perf_cnt0 !== 32'd3 || perf_cnt1 !== 32'd2) begin n_bad++;
            $display("FAIL perf_counts: got %0d %0d want 3 2", perf_cnt0, perf_cnt1); end
        force dut.perf_cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_cnt0_q;
        do_op(0, 32'd6, 32'd6, 4'd0);
        n_cmp++; if (perf_cnt0 !== 32'hFFFF_FFFF || perf_cnt1 !== 32'd2) begin n_bad++;
            $display("FAIL perf_saturate: got %h %0d want ffffffff 2", perf_cnt0, perf_cnt1); end
`else
        n_cmp++; if (perf_cnt0 !== 32'd0 || perf_cnt1 !== 32'd0) begin n_bad++;
            $display("FAIL perf_tied: got %0d %0d want 0 0", perf_cnt0, perf_cnt1); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
